// File: rtl/iopage_defs.sv
// Shared definitions for the I/O-page bus initiator: FSM encoding, well-known
// register addresses and the default decode timeout.
package iopage_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } state_e;

    localparam logic [12:0] ADDR_PSW         = 13'o17776;
    localparam logic [12:0] ADDR_STACK_LIMIT = 13'o17774;

    localparam int DEFAULT_TIMEOUT = 8;

endpackage

// File: rtl/iopage_master.sv
// I/O-page bus initiator: runs one strobed cycle per CPU request and returns
// either read data with an ack or a bus error after TIMEOUT undecoded cycles.
module iopage_master
    import iopage_defs::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_byte,
    input  logic [12:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_buserr,
    output logic [12:0] iopage_addr,
    output logic [15:0] iopage_data_out,
    output logic        iopage_rd,
    output logic        iopage_wr,
    output logic        iopage_byte_op,
    input  logic        iopage_decode,
    input  logic [15:0] iopage_data_in
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [12:0]        addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic               byte_q, byte_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;

    // NOTE: every flop here is a plain register (no memory array), so all of
    // them take their reset value; the bus must be quiet right after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            byte_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            byte_q  <= byte_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        byte_d  = byte_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    // Byte writes are mirrored so both lanes carry the byte.
                    wdata_d = cpu_byte ? {cpu_wdata[7:0], cpu_wdata[7:0]} : cpu_wdata;
                    byte_d  = cpu_byte;
                    rd_d    = ~cpu_we;
                    wr_d    = cpu_we;
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (iopage_decode) begin
                    if (rd_q) rdata_d = iopage_data_in;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE, ST_ERR: state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
    end

    assign cpu_rdata       = rdata_q;
    assign cpu_ack         = ack_q;
    assign cpu_buserr      = err_q;
    assign iopage_addr     = addr_q;
    assign iopage_data_out = wdata_q;
    assign iopage_rd       = rd_q;
    assign iopage_wr       = wr_q;
    assign iopage_byte_op  = byte_q;

endmodule

// File: tb/tb_iopage_master.sv
// Self-checking bench for iopage_master: directed scenarios plus randomized
// transactions scored against a transaction-level model of the bus protocol.
module tb_iopage_master;
    import iopage_defs::*;

    localparam int TO = DEFAULT_TIMEOUT;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_byte;
    logic [12:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ack, cpu_buserr;
    logic [12:0] iopage_addr;
    logic [15:0] iopage_data_out;
    logic        iopage_rd, iopage_wr, iopage_byte_op;
    logic        iopage_decode;
    logic [15:0] iopage_data_in;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_rdata;

    always #5 clk = ~clk;

    iopage_master #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_byte        (cpu_byte),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_rdata       (cpu_rdata),
        .cpu_ack         (cpu_ack),
        .cpu_buserr      (cpu_buserr),
        .iopage_addr     (iopage_addr),
        .iopage_data_out (iopage_data_out),
        .iopage_rd       (iopage_rd),
        .iopage_wr       (iopage_wr),
        .iopage_byte_op  (iopage_byte_op),
        .iopage_decode   (iopage_decode),
        .iopage_data_in  (iopage_data_in)
    );

    function automatic logic [15:0] out_vec();
        return cpu_rdata | 16'(iopage_addr) | iopage_data_out;
    endfunction

    // One CPU transaction. dly = strobe cycle on which the responder decodes;
    // 0 or anything above TO means no responder. Called and returns at a
    // negedge with the DUT in IDLE.
    task automatic run_txn(input string name, input logic we, input logic byt,
                           input logic [12:0] addr, input logic [15:0] wd,
                           input int dly, input logic [15:0] rv);
        int          cyc       = 0;
        int          width     = 0;
        int          end_cyc   = -1;
        bit          got_ack   = 0;
        bit          got_err   = 0;
        bit          bus_bad   = 0;
        bit          both      = 0;
        logic [15:0] rd_at_end = '0;
        logic [15:0] exp_dout  = byt ? {wd[7:0], wd[7:0]} : wd;
        bit          decodes   = (dly >= 1 && dly <= TO);
        int          exp_width = decodes ? dly : TO;

        cpu_req = 1'b1; cpu_we = we; cpu_byte = byt; cpu_addr = addr; cpu_wdata = wd;
        iopage_decode  = 1'($urandom);
        iopage_data_in = 16'($urandom);
        while (end_cyc < 0 && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (iopage_rd || iopage_wr) begin
                width++;
                if (iopage_addr !== addr || iopage_data_out !== exp_dout ||
                    iopage_byte_op !== byt || iopage_rd !== !we || iopage_wr !== we)
                    bus_bad = 1;
                iopage_decode  = (width == dly);
                iopage_data_in = iopage_decode ? rv : 16'($urandom);
            end else begin
                iopage_decode  = 1'($urandom);
                iopage_data_in = 16'($urandom);
            end
            if (cpu_ack && cpu_buserr) both = 1;
            if (cpu_ack || cpu_buserr) begin
                end_cyc   = cyc;
                got_ack   = cpu_ack;
                got_err   = cpu_buserr;
                rd_at_end = cpu_rdata;
                cpu_req   = 1'b0;
            end
        end
        cpu_req = 1'b0;
        if (decodes && !we) exp_rdata = rv;

        total++;
        if (end_cyc < 0) begin
            bad++;
            $display("FAIL %s completion: no ack/buserr within 64 cycles, required one", name);
        end
        total++;
        if (width !== exp_width) begin
            bad++;
            $display("FAIL %s strobe_width got=%0d exp=%0d", name, width, exp_width);
        end
        total++;
        if ({got_ack, got_err} !== {decodes, !decodes}) begin
            bad++;
            $display("FAIL %s outcome ack/err got=%b%b exp=%b%b", name, got_ack, got_err, decodes, !decodes);
        end
        total++;
        if (end_cyc !== exp_width + 1) begin
            bad++;
            $display("FAIL %s latency got=%0d exp=%0d", name, end_cyc, exp_width + 1);
        end
        total++;
        if (rd_at_end !== exp_rdata) begin
            bad++;
            $display("FAIL %s cpu_rdata got=%h exp=%h", name, rd_at_end, exp_rdata);
        end
        total++;
        if (bus_bad || both) begin
            bad++;
            $display("FAIL %s bus_fields got=bad(%0b) both(%0b) exp=0 0", name, bus_bad, both);
        end

        @(negedge clk);
        total++;
        if ({iopage_rd, iopage_wr, cpu_ack, cpu_buserr} !== 4'b0) begin
            bad++;
            $display("FAIL %s idle_after got=%b exp=0000", name,
                     {iopage_rd, iopage_wr, cpu_ack, cpu_buserr});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b1;
        cpu_addr = 13'($urandom); cpu_wdata = 16'($urandom);
        iopage_decode = 1'b1; iopage_data_in = 16'($urandom);
        repeat (3) @(negedge clk);
        total++;
        if ({out_vec(), iopage_rd, iopage_wr, iopage_byte_op, cpu_ack, cpu_buserr} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs got rdata=%h addr=%h dout=%h rd=%b wr=%b byte=%b ack=%b err=%b exp=all 0",
                     cpu_rdata, iopage_addr, iopage_data_out, iopage_rd, iopage_wr,
                     iopage_byte_op, cpu_ack, cpu_buserr);
        end
        cpu_req = 1'b0;
        reset   = 1'b0;
        exp_rdata = '0;
        @(negedge clk);
    endtask

    task automatic test_word_write();
        run_txn("word_write", 1'b1, 1'b0, ADDR_PSW, 16'o000340, 1, 16'h0);
    endtask

    task automatic test_word_read();
        run_txn("word_read", 1'b0, 1'b0, ADDR_PSW, 16'h0, 1, 16'o170017);
    endtask

    task automatic test_byte_write();
        run_txn("byte_write", 1'b1, 1'b1, 13'o17777, 16'o000123, 1, 16'h0);
        total++;
        if ({iopage_data_out, iopage_byte_op} !== {16'o051523, 1'b1}) begin
            bad++;
            $display("FAIL byte_write_hold got dout=%o byte=%b exp dout=051523 byte=1",
                     iopage_data_out, iopage_byte_op);
        end
    endtask

    task automatic test_no_responder();
        run_txn("no_responder", 1'b0, 1'b0, 13'o17000, 16'h0, 0, 16'hffff);
    endtask

    task automatic test_slow_decode();
        run_txn("slow_decode", 1'b0, 1'b0, ADDR_STACK_LIMIT, 16'h0, 3, 16'h5a3c);
    endtask

    task automatic test_reset_mid_write();
        int  width = 0;
        int  guard = 0;
        bit  stray = 0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b0;
        cpu_addr = ADDR_PSW; cpu_wdata = 16'hbeef;
        iopage_decode = 1'b0;
        while (width < 2 && guard < 20) begin
            @(negedge clk);
            guard++;
            if (iopage_wr) width++;
        end
        reset = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        total++;
        if ({out_vec(), iopage_rd, iopage_wr, iopage_byte_op, cpu_ack, cpu_buserr} !== 21'd0 ||
            width != 2) begin
            bad++;
            $display("FAIL reset_mid_write got wr=%b addr=%h dout=%h width=%0d exp all 0 width=2",
                     iopage_wr, iopage_addr, iopage_data_out, width);
        end
        reset = 1'b0;
        exp_rdata = '0;
        iopage_decode = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (cpu_ack || cpu_buserr || iopage_wr || iopage_rd) stray = 1;
        end
        iopage_decode = 1'b0;
        total++;
        if (stray) begin
            bad++;
            $display("FAIL reset_abort got stray ack/err/strobe=1 exp=0");
        end
        run_txn("read_after_reset", 1'b0, 1'b0, ADDR_PSW, 16'h0, 2, 16'h1234);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            run_txn("random", 1'($urandom), 1'($urandom), 13'($urandom), 16'($urandom),
                    int'($urandom_range(0, TO + 2)), 16'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_word_read();
        test_byte_write();
        test_no_responder();
        test_slow_decode();
        test_reset_mid_write();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
